// File: rtl/bfly_fac8_1.sv
// Radix-2 butterfly over half-frames: first half of a frame is buffered, second half is
// paired lane-by-lane with it. Optional SOF alignment check: define BFLY_FAC8_1_SOF_CHECK_EN.
module bfly_fac8_1 #(
   parameter int IN_WIDTH   = 10,
   parameter int WIDTH      = 11,
   parameter int DEPTH      = 16,
   parameter int HALF_BEATS = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       din_valid,
   input  logic                       din_sof,
   input  logic signed [IN_WIDTH-1:0] din_R      [DEPTH],
   input  logic signed [IN_WIDTH-1:0] din_Q      [DEPTH],
   output logic signed [WIDTH-1:0]    dout_R_add [DEPTH],
   output logic signed [WIDTH-1:0]    dout_R_sub [DEPTH],
   output logic signed [WIDTH-1:0]    dout_Q_add [DEPTH],
   output logic signed [WIDTH-1:0]    dout_Q_sub [DEPTH],
   output logic [2:0]                 select,
   output logic                       dout_valid,
   output logic                       frame_err
);

   localparam int CNT_W = (HALF_BEATS > 1) ? $clog2(HALF_BEATS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_BEATS - 1);

   typedef enum logic {FILL = 1'b0, CALC = 1'b1} state_t;

   state_t                     state;
   logic [CNT_W-1:0]           cnt;
   logic signed [IN_WIDTH-1:0] mem_r [HALF_BEATS][DEPTH];
   logic signed [IN_WIDTH-1:0] mem_q [HALF_BEATS][DEPTH];

   logic                       resync;
   logic                       mem_we;
   logic [CNT_W-1:0]           wr_slot;
   logic                       vld_p0;

   function automatic logic signed [WIDTH-1:0] bfly_add(
      input logic signed [IN_WIDTH-1:0] a,
      input logic signed [IN_WIDTH-1:0] b);
      return WIDTH'(a) + WIDTH'(b);
   endfunction

   function automatic logic signed [WIDTH-1:0] bfly_sub(
      input logic signed [IN_WIDTH-1:0] a,
      input logic signed [IN_WIDTH-1:0] b);
      return WIDTH'(a) - WIDTH'(b);
   endfunction

`ifdef BFLY_FAC8_1_SOF_CHECK_EN
   // A marked beat anywhere but frame beat 0 restarts the frame from that beat.
   assign resync = din_valid && din_sof && !(state == FILL && cnt == '0);
`else
   logic unused_sof;
   assign unused_sof = din_sof;
   assign resync     = 1'b0;
`endif

   assign wr_slot = resync ? '0 : cnt;
   assign mem_we  = din_valid && (resync || state == FILL);
   assign vld_p0  = din_valid && !resync && state == CALC;

   // p0: half-frame buffer, data only
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[wr_slot][i] <= din_R[i];
            mem_q[wr_slot][i] <= din_Q[i];
         end
      end
   end

   // p0 -> p1: frame sequencing and registered butterfly results
   always_ff @(posedge clk) begin
      if (rst_n) begin
         state      <= FILL;
         cnt        <= '0;
         dout_valid <= 1'b0;
         select     <= 3'd0;
         for (int i = 0; i < DEPTH; i++) begin
            dout_R_add[i] <= '0;
            dout_R_sub[i] <= '0;
            dout_Q_add[i] <= '0;
            dout_Q_sub[i] <= '0;
         end
      end else begin
         dout_valid <= vld_p0;
         if (resync) begin
            state <= (HALF_BEATS == 1) ? CALC : FILL;
            cnt   <= (HALF_BEATS == 1) ? '0 : CNT_W'(1);
         end else if (din_valid) begin
            if (cnt == CNT_LAST) begin
               cnt   <= '0;
               state <= (state == FILL) ? CALC : FILL;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
         if (vld_p0) begin
            select <= 3'(cnt);
            for (int i = 0; i < DEPTH; i++) begin
               dout_R_add[i] <= bfly_add(mem_r[cnt][i], din_R[i]);
               dout_R_sub[i] <= bfly_sub(mem_r[cnt][i], din_R[i]);
               dout_Q_add[i] <= bfly_add(mem_q[cnt][i], din_Q[i]);
               dout_Q_sub[i] <= bfly_sub(mem_q[cnt][i], din_Q[i]);
            end
         end
      end
   end

`ifdef BFLY_FAC8_1_SOF_CHECK_EN
   always_ff @(posedge clk) begin
      if (rst_n)
         frame_err <= 1'b0;
      else if (resync)
         frame_err <= 1'b1;
   end
`else
   assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_bfly_fac8_1.sv
// Directed bench for bfly_fac8_1: frame model feeds a scoreboard queue, monitor pops on dout_valid.
module tb_bfly_fac8_1;

   localparam int IW = 10;
   localparam int W  = 11;
   localparam int D  = 16;
   localparam int HB = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 din_valid;
   logic                 din_sof;
   logic signed [IW-1:0] din_R      [D];
   logic signed [IW-1:0] din_Q      [D];
   logic signed [W-1:0]  dout_R_add [D];
   logic signed [W-1:0]  dout_R_sub [D];
   logic signed [W-1:0]  dout_Q_add [D];
   logic signed [W-1:0]  dout_Q_sub [D];
   logic [2:0]           select;
   logic                 dout_valid;
   logic                 frame_err;

   bfly_fac8_1 #(.IN_WIDTH(IW), .WIDTH(W), .DEPTH(D), .HALF_BEATS(HB)) dut (
      .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din_sof(din_sof),
      .din_R(din_R), .din_Q(din_Q),
      .dout_R_add(dout_R_add), .dout_R_sub(dout_R_sub),
      .dout_Q_add(dout_Q_add), .dout_Q_sub(dout_Q_sub),
      .select(select), .dout_valid(dout_valid), .frame_err(frame_err)
   );

   typedef struct packed {
      logic [D-1:0][W-1:0] ra;
      logic [D-1:0][W-1:0] rs;
      logic [D-1:0][W-1:0] qa;
      logic [D-1:0][W-1:0] qs;
      logic [2:0]          sel;
      int                  cyc;
   } exp_t;

   exp_t sb[$];
   exp_t last;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   bit   gap_mode = 1'b0;
   bit   prev_vld = 1'b0;

   // reference frame model
   int   m_state = 0;
   int   m_cnt   = 0;
   bit   m_err   = 1'b0;
   int   m_r [HB][D];
   int   m_q [HB][D];

   task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst_n) begin
         chk("rst_dout_valid", dout_valid, 0);
         chk("rst_select", select, 0);
         chk("rst_frame_err", frame_err, 0);
         for (int l = 0; l < D; l++) begin
            chk("rst_R_add", dout_R_add[l], 0);
            chk("rst_R_sub", dout_R_sub[l], 0);
            chk("rst_Q_add", dout_Q_add[l], 0);
            chk("rst_Q_sub", dout_Q_sub[l], 0);
         end
         last     = '0;
         prev_vld = 1'b0;
      end else begin
         if (dout_valid) begin
            chk("unexpected_valid", sb.size() != 0, 1);
            if (sb.size() != 0) begin
               last = sb.pop_front();
               chk("latency_cycle", cyc, last.cyc);
            end
            if (gap_mode) chk("valid_back_to_back", prev_vld, 0);
         end
         // while dout_valid=0 these compare against the previous result (hold)
         chk("select", select, last.sel);
         for (int l = 0; l < D; l++) begin
            chk("R_add", dout_R_add[l], $signed(last.ra[l]));
            chk("R_sub", dout_R_sub[l], $signed(last.rs[l]));
            chk("Q_add", dout_Q_add[l], $signed(last.qa[l]));
            chk("Q_sub", dout_Q_sub[l], $signed(last.qs[l]));
         end
         chk("frame_err", frame_err, m_err);
         prev_vld = dout_valid;
      end
   end

   task automatic set_lanes(input int r, input int q, input bit rnd);
      for (int l = 0; l < D; l++) begin
         din_R[l] = rnd ? IW'($urandom) : IW'(r);
         din_Q[l] = rnd ? IW'($urandom) : IW'(q);
      end
   endtask

   task automatic drive_beat(input bit sof);
      exp_t e;
      bit   rs;
      e         = '0;
      din_valid = 1'b1;
      din_sof   = sof;
      rs        = 1'b0;
`ifdef BFLY_FAC8_1_SOF_CHECK_EN
      rs = sof && !(m_state == 0 && m_cnt == 0);
`endif
      if (rs) begin
         m_err = 1'b1;
         for (int l = 0; l < D; l++) begin
            m_r[0][l] = din_R[l];
            m_q[0][l] = din_Q[l];
         end
         m_state = (HB == 1) ? 1 : 0;
         m_cnt   = (HB == 1) ? 0 : 1;
      end else if (m_state == 0) begin
         for (int l = 0; l < D; l++) begin
            m_r[m_cnt][l] = din_R[l];
            m_q[m_cnt][l] = din_Q[l];
         end
         if (m_cnt == HB - 1) begin
            m_cnt   = 0;
            m_state = 1;
         end else m_cnt++;
      end else begin
         for (int l = 0; l < D; l++) begin
            e.ra[l] = W'(m_r[m_cnt][l] + int'(din_R[l]));
            e.rs[l] = W'(m_r[m_cnt][l] - int'(din_R[l]));
            e.qa[l] = W'(m_q[m_cnt][l] + int'(din_Q[l]));
            e.qs[l] = W'(m_q[m_cnt][l] - int'(din_Q[l]));
         end
         e.sel = 3'(m_cnt);
         e.cyc = cyc + 1;
         sb.push_back(e);
         if (m_cnt == HB - 1) begin
            m_cnt   = 0;
            m_state = 0;
         end else m_cnt++;
      end
      @(negedge clk);
      din_valid = 1'b0;
      din_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         din_valid = 1'b0;
         din_sof   = 1'($urandom);
         set_lanes(0, 0, 1'b1);
         @(negedge clk);
      end
      din_sof = 1'b0;
   endtask

   // valid and sof held high during reset: reset must win
   task automatic do_reset(input int n);
      rst_n     = 1'b1;
      din_valid = 1'b1;
      din_sof   = 1'b1;
      set_lanes(0, 0, 1'b1);
      m_state = 0;
      m_cnt   = 0;
      m_err   = 1'b0;
      repeat (n) @(negedge clk);
      rst_n     = 1'b0;
      din_valid = 1'b0;
      din_sof   = 1'b0;
   endtask

   task automatic send_frame(input int fr, input int fq, input int cr, input int cq,
                             input bit rnd, input int gap, input int sof_at, input int nbeats);
      for (int b = 0; b < nbeats; b++) begin
         if (b < HB) set_lanes(fr, fq, rnd);
         else        set_lanes(cr, cq, rnd);
         drive_beat(b == sof_at);
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      rst_n     = 1'b1;
      din_valid = 1'b0;
      din_sof   = 1'b0;
      set_lanes(0, 0, 1'b0);
      @(negedge clk);
      do_reset(2);

      // basic frame, then extremes and random frames back to back
      send_frame(10, 8, -5, -4, 1'b0, 0, 0, 2*HB);
      send_frame(511, 0, 511, 0, 1'b0, 0, 0, 2*HB);
      send_frame(-512, -512, 511, -512, 1'b0, 0, 0, 2*HB);
      for (int f = 0; f < 3; f++) send_frame(0, 0, 0, 0, 1'b1, 0, 0, 2*HB);
      idle(2);

      // stalls between beats
      gap_mode = 1'b1;
      send_frame(10, 8, -5, -4, 1'b0, 3, 0, 2*HB);
      gap_mode = 1'b0;
      idle(2);

      // reset after two CALC beats, then a fresh frame
      send_frame(0, 0, 0, 0, 1'b1, 0, 0, HB + 2);
      do_reset(1);
      send_frame(0, 0, 0, 0, 1'b1, 0, 0, 2*HB);
      idle(1);

      // misplaced start-of-frame on beat 5
      send_frame(0, 0, 0, 0, 1'b1, 0, 5, 2*HB);
      send_frame(0, 0, 0, 0, 1'b1, 0, -1, 2*HB);
      idle(2);
      do_reset(1);
      send_frame(0, 0, 0, 0, 1'b1, 1, 0, 2*HB);

      idle(3);
      chk("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bfly_fac8_1.md
BFLY_FAC8_1 -- requirements
Module: bfly_fac8_1

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 10, signed input sample width.
REQ-002 SHALL have parameter WIDTH, default 11 (= IN_WIDTH+1), signed output width, matching the downstream twiddle-multiplier input.
REQ-003 SHALL have parameter DEPTH, default 16, lanes (complex samples) per beat.
REQ-004 SHALL have parameter HALF_BEATS, default 4, beats per half-frame; legal range 1..8.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst_n, input, 1, synchronous reset, active-high (1 = reset), sampled on rising clk.
REQ-007 SHALL have port din_valid, input, 1, input beat qualifier.
REQ-008 SHALL have port din_sof, input, 1, start-of-frame marker, meaningful only with din_valid.
REQ-009 SHALL have ports din_R, din_Q, input, DEPTH x IN_WIDTH signed arrays, real/imag lanes.
REQ-010 SHALL have ports dout_R_add, dout_R_sub, dout_Q_add, dout_Q_sub, output, DEPTH x WIDTH signed arrays, butterfly results.
REQ-011 SHALL have port select, output, 3, twiddle index for the downstream multiplier.
REQ-012 SHALL have port dout_valid, output, 1, output beat qualifier.
REQ-013 SHALL have port frame_err, output, 1, sticky frame-alignment error.

Function
REQ-014 Frame SHALL be 2*HALF_BEATS accepted beats; a beat is accepted on any rising clk with din_valid=1; gaps with din_valid=0 SHALL stall all state.
REQ-015 FSM SHALL have states FILL and CALC plus beat counter cnt (0..HALF_BEATS-1).
REQ-016 In FILL, accepted beat SHALL be written to buffer slot cnt; at cnt=HALF_BEATS-1 cnt wraps to 0 and state -> CALC.
REQ-017 In CALC, accepted beat b SHALL be paired lane-by-lane with buffer slot cnt: add = buf + b, sub = buf - b, both sign-extended to WIDTH, full precision, no saturation or scaling.
REQ-018 In CALC at cnt=HALF_BEATS-1, cnt SHALL wrap to 0 and state -> FILL.
REQ-019 Outputs SHALL be registered; latency is exactly 1 clk from the accepted CALC beat to dout_valid=1 with its results.
REQ-020 select SHALL equal the cnt of the CALC beat producing the output, registered with the data.
REQ-021 dout_valid SHALL be 1 for exactly one cycle per accepted CALC beat; data and select SHALL hold their last values while dout_valid=0.
REQ-022 A FILL beat SHALL never produce dout_valid.
REQ-023 Back-to-back frames with no idle cycle SHALL be supported at full rate.

Reset
REQ-024 While rst_n=1: state=FILL, cnt=0, dout_valid=0, select=0, all dout lanes=0, frame_err=0. The buffer is not cleared.
REQ-025 Reset mid-frame SHALL discard the partial frame; the first accepted beat after release is frame beat 0.
REQ-026 Reset SHALL take priority over a simultaneous din_valid.

Configuration
REQ-027 Macro BFLY_FAC8_1_SOF_CHECK_EN SHALL control frame-alignment checking.
REQ-028 With the macro defined, an accepted beat with din_sof=1 while not (state=FILL and cnt=0) SHALL set frame_err=1 (sticky until reset) and resync: the beat is stored as FILL slot 0, cnt=1 (or state=CALC, cnt=0 when HALF_BEATS=1), and no output is produced for it.
REQ-029 Without the macro, din_sof SHALL be ignored and frame_err SHALL be constant 0.

Verification
REQ-030 Reset then 8 continuous beats, HALF_BEATS=4, FILL lanes R=10/Q=8, CALC lanes R=-5/Q=-4 -> 4 dout_valid pulses, each 1 clk after a CALC beat; R_add=5, R_sub=15, Q_add=4, Q_sub=12; select 0,1,2,3.
REQ-031 Extremes: FILL R=511, CALC R=511 -> R_add=1022; FILL R=-512, CALC R=511 -> R_sub=-1023; no wrap at WIDTH=11.
REQ-032 Same frame as REQ-030 with din_valid=0 for 3 cycles between every beat -> identical output values and select sequence; dout_valid never high for 2 consecutive cycles.
REQ-033 rst_n=1 after 2 CALC beats, then one full frame -> no pulse from the aborted frame; the new frame gives 4 correct pulses, select restarts at 0.
REQ-034 Macro defined: din_sof=1 on frame beat 5 -> frame_err=1 held; next 4 beats are FILL, next 4 produce outputs. Macro undefined: same stimulus -> frame_err=0, original alignment kept.
